// File: rtl/game_controller.sv
// Turn-based game controller: synchronizes the confirm button, issues one move
// request per press to an external move checker and tracks turn/score state.
module game_controller #(
    parameter logic [1:0] FIRST_PLAYER = 2'b01,
    parameter int         SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sel,
    input  logic       enter,
    input  logic       valid,
    input  logic [1:0] outcome,
    output logic [3:0] move,
    output logic [1:0] user,
    output logic       move_req,
    output logic [1:0] turn,
    output logic [3:0] move_count,
    output logic       err,
    output logic       game_over,
    output logic [1:0] result,
    output logic [1:0] dbg_state
);

    // Handshake: move_req is a one-cycle strobe with move/user stable in that
    // cycle; valid is sampled only in that same cycle, outcome one cycle later.

    typedef enum logic [1:0] {
        S_WAIT_INPUT = 2'd0,
        S_ISSUE      = 2'd1,
        S_CHECK      = 2'd2,
        S_DONE       = 2'd3
    } state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_enter_prev;
    logic                   w_enter_pulse;
    logic                   w_sel_legal;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync       <= '0;
            r_enter_prev <= 1'b0;
        end else begin
            r_sync       <= {r_sync[SYNC_STAGES-2:0], enter};
            r_enter_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    // One pulse per press no matter how long the button is held.
    assign w_enter_pulse = r_sync[SYNC_STAGES-1] & ~r_enter_prev;
    assign w_sel_legal   = (sel >= 4'd1) && (sel <= 4'd9);
    assign dbg_state     = r_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_WAIT_INPUT;
            turn       <= FIRST_PLAYER;
            move       <= 4'd0;
            user       <= 2'd0;
            move_req   <= 1'b0;
            err        <= 1'b0;
            move_count <= 4'd0;
            game_over  <= 1'b0;
            result     <= 2'd0;
        end else begin
            move_req <= 1'b0;
            err      <= 1'b0;
            case (r_state)
                S_WAIT_INPUT: begin
                    if (w_enter_pulse) begin
                        if (w_sel_legal) begin
                            move     <= sel;
                            user     <= turn;
                            move_req <= 1'b1;
                            r_state  <= S_ISSUE;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    if (valid) begin
                        if (move_count != 4'd9) begin
                            move_count <= move_count + 4'd1;
                        end
                        r_state <= S_CHECK;
                    end else begin
                        // Rejected move: same player retries.
                        err     <= 1'b1;
                        r_state <= S_WAIT_INPUT;
                    end
                end
                S_CHECK: begin
                    if (outcome != 2'd0) begin
                        result    <= outcome;
                        game_over <= 1'b1;
                        r_state   <= S_DONE;
                    end else if (move_count == 4'd9) begin
                        result    <= 2'd3;
                        game_over <= 1'b1;
                        r_state   <= S_DONE;
                    end else begin
                        turn    <= {turn[0], turn[1]};
                        r_state <= S_WAIT_INPUT;
                    end
                end
                S_DONE: begin
                    r_state <= S_DONE;
                end
                default: begin
                    r_state <= S_WAIT_INPUT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_controller.sv
// Bench for game_controller: directed presses, expected requests/errors queued
// by the driver and popped by a monitor whenever the DUT strobes an output.
module tb_game_controller;

    logic       clk;
    logic       rst;
    logic [3:0] sel;
    logic       enter;
    logic       valid;
    logic [1:0] outcome;
    logic [3:0] move;
    logic [1:0] user;
    logic       move_req;
    logic [1:0] turn;
    logic [3:0] move_count;
    logic       err;
    logic       game_over;
    logic [1:0] result;
    logic [1:0] dbg_state;

    int checks = 0;
    int errors = 0;

    // Entry: [6]=1 move request / 0 error pulse, [5:2]=move, [1:0]=user
    logic [6:0] exp_q[$];
    logic       prev_req;

    game_controller #(.FIRST_PLAYER(2'b01), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .sel(sel), .enter(enter), .valid(valid),
        .outcome(outcome), .move(move), .user(user), .move_req(move_req),
        .turn(turn), .move_count(move_count), .err(err),
        .game_over(game_over), .result(result), .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        enter = 1'b0;
        sel   = 4'd0;
        repeat (2) @(negedge clk);
        chk("rst_move", {4'd0, move}, 8'd0);
        chk("rst_user", {6'd0, user}, 8'd0);
        chk("rst_req", {7'd0, move_req}, 8'd0);
        chk("rst_turn", {6'd0, turn}, 8'd1);
        chk("rst_count", {4'd0, move_count}, 8'd0);
        chk("rst_err", {7'd0, err}, 8'd0);
        chk("rst_over", {7'd0, game_over}, 8'd0);
        chk("rst_result", {6'd0, result}, 8'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic push_req(input logic [3:0] m, input logic [1:0] u);
        exp_q.push_back({1'b1, m, u});
    endtask

    task automatic push_err();
        exp_q.push_back(7'd0);
    endtask

    task automatic press(input logic [3:0] s, input int hold);
        sel   = s;
        enter = 1'b1;
        repeat (hold) @(negedge clk);
        enter = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    // monitor
    initial begin
        logic [6:0] e;
        prev_req = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_req = 1'b0;
            end else begin
                if (move_req) begin
                    checks++;
                    if (prev_req) begin
                        errors++;
                        $display("FAIL req_back_to_back: move_req high two cycles running");
                    end
                end
                if (move_req || err) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_event: req=%0b err=%0b move=%0d user=%0d",
                                 move_req, err, move, user);
                    end else begin
                        e = exp_q.pop_front();
                        if (e[6] !== move_req) begin
                            errors++;
                            $display("FAIL event_kind: got req=%0b err=%0b expected req=%0b",
                                     move_req, err, e[6]);
                        end else if (move_req && (e[5:0] !== {move, user})) begin
                            errors++;
                            $display("FAIL req_fields: got move=%0d user=%0d expected move=%0d user=%0d",
                                     move, user, e[5:2], e[1:0]);
                        end
                    end
                end
                prev_req = move_req;
            end
        end
    end

    // stimulus
    initial begin
        bit seen;
        valid   = 1'b1;
        outcome = 2'd0;
        do_reset();

        // Illegal cell codes: two errors, no request
        push_err();
        press(4'd0, 3);
        push_err();
        press(4'd12, 3);
        chk("illegal_turn", {6'd0, turn}, 8'd1);
        chk("illegal_count", {4'd0, move_count}, 8'd0);

        // Move rejected by checker
        valid = 1'b0;
        push_req(4'd3, 2'b01);
        push_err();
        press(4'd3, 3);
        chk("reject_turn", {6'd0, turn}, 8'd1);
        chk("reject_count", {4'd0, move_count}, 8'd0);

        // Long hold: one request only
        valid = 1'b1;
        push_req(4'd5, 2'b01);
        press(4'd5, 20);
        chk("hold_turn", {6'd0, turn}, 8'd2);
        chk("hold_count", {4'd0, move_count}, 8'd1);

        // P1 wins on third accepted P1 move
        push_req(4'd1, 2'b10); press(4'd1, 3);
        push_req(4'd2, 2'b01); press(4'd2, 3);
        push_req(4'd4, 2'b10); press(4'd4, 3);
        chk("mid_turn", {6'd0, turn}, 8'd1);
        outcome = 2'd1;
        push_req(4'd9, 2'b01); press(4'd9, 3);
        chk("win_over", {7'd0, game_over}, 8'd1);
        chk("win_result", {6'd0, result}, 8'd1);
        chk("win_count", {4'd0, move_count}, 8'd5);
        chk("win_turn", {6'd0, turn}, 8'd1);
        press(4'd7, 3);
        chk("done_count", {4'd0, move_count}, 8'd5);
        chk("done_result", {6'd0, result}, 8'd1);

        // Nine moves, forced tie
        outcome = 2'd0;
        do_reset();
        for (int i = 1; i <= 9; i++) begin
            push_req(i[3:0], (i % 2 == 1) ? 2'b01 : 2'b10);
            press(i[3:0], 3);
            if (i == 8) begin
                chk("eight_over", {7'd0, game_over}, 8'd0);
                chk("eight_count", {4'd0, move_count}, 8'd8);
            end
        end
        chk("tie_count", {4'd0, move_count}, 8'd9);
        chk("tie_over", {7'd0, game_over}, 8'd1);
        chk("tie_result", {6'd0, result}, 8'd3);
        press(4'd1, 3);
        chk("tie_hold_count", {4'd0, move_count}, 8'd9);

        // Reset asserted while the request is in flight
        do_reset();
        push_req(4'd6, 2'b01);
        sel   = 4'd6;
        enter = 1'b1;
        seen  = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (move_req) seen = 1'b1;
        end
        chk("issue_reached", {7'd0, seen}, 8'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_req", {7'd0, move_req}, 8'd0);
        chk("abort_move", {4'd0, move}, 8'd0);
        chk("abort_user", {6'd0, user}, 8'd0);
        chk("abort_turn", {6'd0, turn}, 8'd1);
        chk("abort_count", {4'd0, move_count}, 8'd0);
        enter = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        chk("post_abort_turn", {6'd0, turn}, 8'd1);
        chk("post_abort_count", {4'd0, move_count}, 8'd0);

        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size() > 255 ? 8'hFF : 8'(exp_q.size()), 8'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/game_controller.md
GAME_CONTROLLER -- requirements
Module: game_controller

Interface
REQ-001 Parameter FIRST_PLAYER, default 2'b01, SHALL give the player code that moves first after reset (2'b01 = P1, 2'b10 = P2).
REQ-002 Parameter SYNC_STAGES, default 2, SHALL give the number of synchronizer flops on the enter input (legal range 2-3).
REQ-003 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1, SHALL be the asynchronous, active-high reset.
REQ-005 Port sel, input, 4, SHALL carry the cell code chosen by the player: 1-9 = A1..C3; 0 and 10-15 are illegal.
REQ-006 Port enter, input, 1, SHALL be the raw, asynchronous confirm button, active-high.
REQ-007 Port valid, input, 1, SHALL be the move-accepted flag returned by the downstream move checker, sampled only in ISSUE.
REQ-008 Port outcome, input, 2, SHALL be the game result from the move checker: 0 in progress, 1 P1 win, 2 P1 lose, 3 tie.
REQ-009 Port move, output, 4, SHALL be the cell code presented to the move checker.
REQ-010 Port user, output, 2, SHALL be the player code presented with move.
REQ-011 Port move_req, output, 1, SHALL be a one-cycle strobe marking move/user as a new request.
REQ-012 Port turn, output, 2, SHALL be the player whose input is awaited.
REQ-013 Port move_count, output, 4, SHALL be the number of accepted moves (0-9).
REQ-014 Port err, output, 1, SHALL be a one-cycle pulse on a rejected entry.
REQ-015 Port game_over, output, 1, SHALL be high once the game has ended.
REQ-016 Port result, output, 2, SHALL be the final outcome code, valid while game_over=1.

Function
REQ-017 The enter input SHALL pass through SYNC_STAGES flops, then a rising-edge detector; the resulting enter_pulse lasts one cycle per press, regardless of how long the button is held.
REQ-018 The block SHALL implement the FSM states WAIT_INPUT, ISSUE, CHECK and DONE.
REQ-019 In WAIT_INPUT, on enter_pulse with sel in 1..9: latch sel into move, set user=turn, go to ISSUE.
REQ-020 In WAIT_INPUT, on enter_pulse with sel illegal: pulse err for one cycle, stay in WAIT_INPUT, leave move and user unchanged.
REQ-021 In ISSUE: move_req=1 for exactly this cycle, and valid is sampled in the same cycle.
REQ-022 In ISSUE with valid=1: increment move_count and go to CHECK.
REQ-023 In ISSUE with valid=0: pulse err on the next cycle, return to WAIT_INPUT, keep turn unchanged (same player retries).
REQ-024 CHECK SHALL last one cycle and sample outcome there.
REQ-025 In CHECK with outcome!=0: latch result=outcome, set game_over=1, go to DONE.
REQ-026 In CHECK with outcome=0 and move_count=9: latch result=3 (forced tie), set game_over=1, go to DONE.
REQ-027 In CHECK otherwise: toggle turn (01<->10) and return to WAIT_INPUT.
REQ-028 DONE SHALL be terminal until rst: ignore enter, hold all outputs, keep move_req=0 and err=0.
REQ-029 move_count SHALL saturate at 9 and never wrap.
REQ-030 An enter_pulse arriving outside WAIT_INPUT SHALL be discarded, not queued.
REQ-031 move_req SHALL never be high in two consecutive cycles.
REQ-032 Minimum latency from enter_pulse to move_req SHALL be 1 cycle; from move_req to the updated turn, 2 cycles.

Reset
REQ-033 Assertion of rst SHALL immediately force: state=WAIT_INPUT, turn=FIRST_PLAYER, move=0, user=0, move_req=0, err=0, move_count=0, game_over=0, result=0, and all sync/edge flops=0.
REQ-034 rst asserted mid-operation (including ISSUE or CHECK) SHALL abort the pending request, with no move_req issued after deassertion.
REQ-035 The first enter_pulse SHALL be recognizable no earlier than SYNC_STAGES+1 cycles after rst deasserts.

Verification
REQ-036 Scenario: sel=5, enter held high for 20 cycles, valid=1, outcome=0 -> exactly one move_req with move=5 and user=01, then turn=10 and move_count=1.
REQ-037 Scenario: sel=0, press enter; then sel=12, press enter -> err pulses twice, no move_req is issued, turn stays 01.
REQ-038 Scenario: sel=3 pressed with valid=0 -> move_req once, err one cycle later, turn remains 01, move_count remains 0.
REQ-039 Scenario: on the third accepted P1 move, outcome=1 in CHECK -> game_over=1 and result=1; later presses produce no move_req.
REQ-040 Scenario: nine accepted moves with outcome held at 0 -> move_count=9, game_over=1, result=3.
REQ-041 Scenario: rst pulsed while in ISSUE -> all outputs return to their reset values within the reset cycle, turn=FIRST_PLAYER, and no stray move_req appears after release.
